bram_arbiter: RTL

Round-robin arbiter that shares one single-port block RAM (the BRAM or BRAM_clear request/ready interface) between NUM_PORTS requesters. It sits between the CPU/DMA-side masters and the memory. It holds off all grants until the memory reports initialized, and it serializes accesses so that exactly one transaction is outstanding downstream at a time.

---
 rtl/bram_arbiter_pkg.sv | 13 +
 rtl/bram_arbiter_rr_pick.sv | 40 ++++
 rtl/bram_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/bram_arbiter_pkg.sv
// bram_arbiter_pkg: shared types and helpers for the BRAM round-robin arbiter.
package bram_arbiter_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam int MAX_PORTS = 4;

    // Width of a port index; never less than one bit.
    function automatic int port_idx_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/bram_arbiter_rr_pick.sv
// rr_pick: combinational next-grant search over the eligible mask.
// BRAM_ARBITER_FIXED_PRIORITY_EN defined: search always starts at port 0.
// Undefined (default): search starts at last+1 and wraps.
module rr_pick
    import bram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IW        = 1
) (
    input  logic [NUM_PORTS-1:0] eligible_i,
    input  logic [IW-1:0]        last_i,
    output logic [IW-1:0]        grant_o,
    output logic                 valid_o
);

`ifdef BRAM_ARBITER_FIXED_PRIORITY_EN
    logic unused_last;
    assign unused_last = ^last_i;
`endif

    // First eligible port in search order wins.
    always_comb begin
        int idx;
        idx     = 0;
        grant_o = '0;
        valid_o = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef BRAM_ARBITER_FIXED_PRIORITY_EN
            idx = k;
`else
            idx = (int'(last_i) + 1 + k) % NUM_PORTS;
`endif
            if (!valid_o && eligible_i[idx[IW-1:0]]) begin
                valid_o = 1'b1;
                grant_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port BRAM between NUM_PORTS requesters,
// one outstanding transaction at a time, gated by the memory's initialized flag.
// Optional BRAM_ARBITER_FIXED_PRIORITY_EN switches round-robin to fixed priority.
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_PORTS = 2
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_initialized,
    input  logic [NUM_PORTS-1:0]       i_request,
    input  logic [NUM_PORTS-1:0]       i_rw,
    input  logic [NUM_PORTS*32-1:0]    i_address,
    input  logic [NUM_PORTS*WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [NUM_PORTS-1:0]       o_ready,
    output logic                       o_mem_request,
    output logic                       o_mem_rw,
    output logic [31:0]                o_mem_address,
    output logic [WIDTH-1:0]           o_mem_wdata,
    input  logic [WIDTH-1:0]           i_mem_rdata,
    input  logic                       i_mem_ready
);

    localparam int IW = port_idx_w(NUM_PORTS);

    state_t               state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [IW-1:0]        last_q, last_d;
    logic [NUM_PORTS-1:0] served_q, served_d;

    logic [IW-1:0]        pick;
    logic                 pick_vld;

    // A served port stays ineligible until it has dropped its request once.
    rr_pick #(.NUM_PORTS(NUM_PORTS), .IW(IW)) u_pick (
        .eligible_i (i_request & ~served_q),
        .last_i     (last_q),
        .grant_o    (pick),
        .valid_o    (pick_vld)
    );

    // Next-state: grant in IDLE once initialized, retire on memory ready.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        served_d = served_q & i_request;
        case (state_q)
            IDLE: begin
                if (i_initialized && pick_vld) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (i_mem_ready) begin
                    served_d[grant_q] = 1'b1;
                    last_d            = grant_q;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; last resets to the top port so port 0 is searched first.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= IW'(NUM_PORTS - 1);
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            served_q <= served_d;
        end
    end

    // Memory-side mux and ready pass-through, all quiet outside BUSY.
    always_comb begin
        o_mem_request = 1'b0;
        o_mem_rw      = 1'b0;
        o_mem_address = '0;
        o_mem_wdata   = '0;
        o_ready       = '0;
        o_rdata       = '0;
        if (state_q == BUSY) begin
            o_mem_request    = 1'b1;
            o_mem_rw         = i_rw[grant_q];
            o_mem_address    = i_address[grant_q*32 +: 32];
            o_mem_wdata      = i_wdata[grant_q*WIDTH +: WIDTH];
            o_ready[grant_q] = i_mem_ready;
            o_rdata          = i_mem_rdata;
        end
    end

endmodule
